// File: rtl/xbus_arbiter_pkg.sv
// Shared definitions for the two-master system bus arbiter: state encodings,
// master indices and the lock counter width helper.
package xbus_arbiter_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_LOCK_DEF = 4;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    function automatic int arb_lock_w(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/xbus_arbiter_if.sv
// Per-master request/response port of the bus arbiter. The master modport
// drives the request side, the slave modport (the arbiter) drives the response.
interface xbus_arbiter_if
    import xbus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, addr, we, wdata, lock, input ack, rdata, err);
    modport slave  (input req, addr, we, wdata, lock, output ack, rdata, err);
endinterface

// File: rtl/xarb_rr.sv
// Two-way round-robin picker: one-hot grant for the request vector, with prio
// breaking the tie when both masters request.
module xarb_rr
    import xbus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio == M1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Shares the system bus between two masters: round-robin grant with a bounded
// lock, one registered select cycle per transfer and a one-cycle ack.
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
)(
    input  logic              clk,
    input  logic              rst,
    xbus_arbiter_if.slave     m0,
    xbus_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] addr,
    output logic              sel,
    output logic              we,
    output logic [DATA_W-1:0] data_to_wr,
    input  logic [DATA_W-1:0] data_to_rd,
    input  logic              trap_sel
);

    localparam int                LOCK_W   = arb_lock_w(MAX_LOCK);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

    arb_state_e        state, state_next;
    logic              gnt, gnt_next;
    logic              prio, prio_next;
    logic              lock_own, lock_own_next;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_next;
    logic [ADDR_W-1:0] addr_next;
    logic              we_next, sel_next;
    logic [DATA_W-1:0] wdata_next, resp_data;
    logic              ack0_next, ack1_next, err0_next, err1_next;
    logic [DATA_W-1:0] rdata0_next, rdata1_next;

    logic [1:0] req_vec, rr_grant;
    logic       lock_hit, rr_prio, winner;

    assign req_vec  = {m1.req, m0.req};
    assign lock_hit = lock_own && req_vec[gnt] && (lock_cnt < LOCK_MAX);
    // An exhausted lock hands the tie-break to the other master, since prio was
    // left pointing at the lock owner throughout the locked run.
    assign rr_prio  = (lock_own && (lock_cnt >= LOCK_MAX)) ? ~gnt : prio;
    assign winner   = lock_hit ? gnt : (rr_grant == 2'b10);
    assign resp_data = (trap_sel || we) ? '0 : data_to_rd;

    xarb_rr u_rr (
        .req   (req_vec),
        .prio  (rr_prio),
        .grant (rr_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            gnt        <= M0;
            prio       <= M0;
            lock_own   <= 1'b0;
            lock_cnt   <= '0;
            addr       <= '0;
            we         <= 1'b0;
            data_to_wr <= '0;
            sel        <= 1'b0;
            m0.ack     <= 1'b0;
            m0.err     <= 1'b0;
            m0.rdata   <= '0;
            m1.ack     <= 1'b0;
            m1.err     <= 1'b0;
            m1.rdata   <= '0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            prio       <= prio_next;
            lock_own   <= lock_own_next;
            lock_cnt   <= lock_cnt_next;
            addr       <= addr_next;
            we         <= we_next;
            data_to_wr <= wdata_next;
            sel        <= sel_next;
            m0.ack     <= ack0_next;
            m0.err     <= err0_next;
            m0.rdata   <= rdata0_next;
            m1.ack     <= ack1_next;
            m1.err     <= err1_next;
            m1.rdata   <= rdata1_next;
        end
    end

    always_comb begin
        state_next    = state;
        gnt_next      = gnt;
        prio_next     = prio;
        lock_own_next = lock_own;
        lock_cnt_next = lock_cnt;
        addr_next     = addr;
        we_next       = we;
        wdata_next    = data_to_wr;
        sel_next      = 1'b0;
        ack0_next     = 1'b0;
        ack1_next     = 1'b0;
        err0_next     = 1'b0;
        err1_next     = 1'b0;
        rdata0_next   = '0;
        rdata1_next   = '0;

        case (state)
            ARB_IDLE: begin
                if (|req_vec) begin
                    state_next    = ARB_ISSUE;
                    sel_next      = 1'b1;
                    gnt_next      = winner;
                    lock_own_next = winner ? m1.lock  : m0.lock;
                    addr_next     = winner ? m1.addr  : m0.addr;
                    we_next       = winner ? m1.we    : m0.we;
                    wdata_next    = winner ? m1.wdata : m0.wdata;
                    if (lock_hit) begin
                        if (req_vec[~gnt])
                            lock_cnt_next = lock_cnt + LOCK_W'(1);
                    end else begin
                        lock_cnt_next = '0;
                    end
                end
            end
            ARB_ISSUE: begin
                state_next = ARB_RESP;
                if (gnt == M1) begin
                    ack1_next   = 1'b1;
                    err1_next   = trap_sel;
                    rdata1_next = resp_data;
                end else begin
                    ack0_next   = 1'b1;
                    err0_next   = trap_sel;
                    rdata0_next = resp_data;
                end
            end
            ARB_RESP: begin
                state_next = ARB_IDLE;
                if (!lock_own)
                    prio_next = ~gnt;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Scoreboard bench for xbus_arbiter: directed transfers push expected bus and
// ack records; a negedge monitor pops and compares whenever sel or ack appears.
module tb_xbus_arbiter;
    import xbus_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int ML = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic          m;
        logic [DW-1:0] rdata;
        logic          err;
    } ack_exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] bus_addr;
    logic          bus_sel;
    logic          bus_we;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] data_to_rd;
    logic          trap_sel;
    logic [DW-1:0] slave_data;
    logic          slave_trap;

    bus_exp_t exp_bus[$];
    ack_exp_t exp_ack[$];
    int       sel_cycles[$];
    int       checks;
    int       errors;
    int       cycle;
    logic     sel_prev;

    xbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    xbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_if),
        .m1         (m1_if),
        .addr       (bus_addr),
        .sel        (bus_sel),
        .we         (bus_we),
        .data_to_wr (bus_wdata),
        .data_to_rd (data_to_rd),
        .trap_sel   (trap_sel)
    );

    assign data_to_rd = slave_data;
    assign trap_sel   = slave_trap & bus_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not as expected (t=%0t)", name, $time);
    endtask

    task automatic driveMaster(input logic m, input logic r, input logic [AW-1:0] a,
                               input logic w, input logic [DW-1:0] wd, input logic lk);
        if (m) begin
            m1_if.req = r; m1_if.addr = a; m1_if.we = w; m1_if.wdata = wd; m1_if.lock = lk;
        end else begin
            m0_if.req = r; m0_if.addr = a; m0_if.we = w; m0_if.wdata = wd; m0_if.lock = lk;
        end
    endtask

    task automatic pushExp(input logic m, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic e);
        bus_exp_t b;
        ack_exp_t k;
        b.addr = a; b.we = w; b.wdata = wd;
        k.m = m; k.rdata = rd; k.err = e;
        exp_bus.push_back(b);
        exp_ack.push_back(k);
    endtask

    // One transfer from a single master; returns cycles from request to ack.
    task automatic applyStimulus(input logic m, input logic [AW-1:0] a, input logic w,
                                 input logic [DW-1:0] wd, input logic [DW-1:0] resp,
                                 input logic trap, input logic [DW-1:0] exp_rd,
                                 input logic exp_err, output int waits);
        logic got;
        pushExp(m, a, w, wd, exp_rd, exp_err);
        slave_data = resp;
        slave_trap = trap;
        driveMaster(m, 1'b1, a, w, wd, 1'b0);
        got   = 1'b0;
        waits = 0;
        while (!got && waits < 20) begin
            @(posedge clk); #1;
            waits++;
            got = m ? m1_if.ack : m0_if.ack;
        end
        if (!got) failNow("ack_timeout");
        @(posedge clk); #1;
        driveMaster(m, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic waitAcks(input int n);
        int cnt;
        int budget;
        cnt    = 0;
        budget = 0;
        while (cnt < n && budget < 10 * n + 10) begin
            @(posedge clk); #1;
            budget++;
            if (m0_if.ack || m1_if.ack) cnt++;
        end
        if (cnt < n) failNow("multi_ack_timeout");
    endtask

    task automatic doReset();
        driveMaster(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        driveMaster(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        slave_trap = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Scoreboard monitor: compares bus select cycles and acks against the queues.
    always @(negedge clk) begin
        bus_exp_t b;
        ack_exp_t k;
        cycle = cycle + 1;
        if (bus_sel === 1'b1) begin
            if (sel_prev) failNow("sel_width");
            else if (exp_bus.size() == 0) failNow("unexpected_sel");
            else begin
                b = exp_bus.pop_front();
                checkOutput("bus_addr", 64'(bus_addr), 64'(b.addr));
                checkOutput("bus_we", 64'(bus_we), 64'(b.we));
                checkOutput("bus_wdata", 64'(bus_wdata), 64'(b.wdata));
                sel_cycles.push_back(cycle);
            end
        end
        if (m0_if.ack === 1'b1 || m1_if.ack === 1'b1) begin
            checkOutput("ack_after_sel", 64'(sel_prev), 64'(1));
            if (m0_if.ack && m1_if.ack) failNow("both_ack");
            else if (exp_ack.size() == 0) failNow("unexpected_ack");
            else begin
                k = exp_ack.pop_front();
                checkOutput("ack_master", 64'(m1_if.ack), 64'(k.m));
                checkOutput("ack_rdata", 64'(k.m ? m1_if.rdata : m0_if.rdata), 64'(k.rdata));
                checkOutput("ack_err", 64'(k.m ? m1_if.err : m0_if.err), 64'(k.err));
                checkOutput("idle_rdata", 64'(k.m ? m0_if.rdata : m1_if.rdata), 64'(0));
                checkOutput("idle_err", 64'(k.m ? m0_if.err : m1_if.err), 64'(0));
            end
        end
        sel_prev = (bus_sel === 1'b1);
    end

    initial begin
        int waits;
        int spins;
        checks     = 0;
        errors     = 0;
        cycle      = 0;
        sel_prev   = 1'b0;
        slave_data = '0;
        slave_trap = 1'b0;
        rst        = 1'b1;
        driveMaster(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        driveMaster(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_sel", 64'(bus_sel), 64'(0));
        checkOutput("rst_we", 64'(bus_we), 64'(0));
        checkOutput("rst_addr", 64'(bus_addr), 64'(0));
        checkOutput("rst_wdata", 64'(bus_wdata), 64'(0));
        checkOutput("rst_m0_ack", 64'(m0_if.ack), 64'(0));
        checkOutput("rst_m1_ack", 64'(m1_if.ack), 64'(0));
        checkOutput("rst_m0_err", 64'(m0_if.err), 64'(0));
        checkOutput("rst_m1_err", 64'(m1_if.err), 64'(0));
        checkOutput("rst_m0_rdata", 64'(m0_if.rdata), 64'(0));
        checkOutput("rst_m1_rdata", 64'(m1_if.rdata), 64'(0));

        $display("[TB] single read");
        applyStimulus(M0, 16'h0010, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 1'b0, waits);
        checkOutput("read_latency", 64'(waits), 64'(2));

        $display("[TB] simultaneous requests alternate");
        doReset();
        slave_data = 32'h5555AAAA;
        pushExp(M0, 16'h0020, 1'b0, 32'h0, 32'h5555AAAA, 1'b0);
        pushExp(M1, 16'h0030, 1'b0, 32'h0, 32'h5555AAAA, 1'b0);
        pushExp(M0, 16'h0020, 1'b0, 32'h0, 32'h5555AAAA, 1'b0);
        pushExp(M1, 16'h0030, 1'b0, 32'h0, 32'h5555AAAA, 1'b0);
        sel_cycles.delete();
        driveMaster(M0, 1'b1, 16'h0020, 1'b0, 32'h0, 1'b0);
        driveMaster(M1, 1'b1, 16'h0030, 1'b0, 32'h0, 1'b0);
        waitAcks(4);
        @(posedge clk); #1;
        driveMaster(M0, 1'b0, '0, 1'b0, '0, 1'b0);
        driveMaster(M1, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("alt_sel_count", 64'(sel_cycles.size()), 64'(4));
        for (int i = 1; i < sel_cycles.size(); i++)
            checkOutput("alt_spacing", 64'(sel_cycles[i] - sel_cycles[i-1]), 64'(3));

        $display("[TB] trapped write");
        applyStimulus(M1, 16'h7F00, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h0, 1'b1, waits);

        $display("[TB] lock limit");
        doReset();
        slave_data = 32'h0000_4C4B;
        for (int i = 0; i < 5; i++)
            pushExp(M0, 16'h0040, 1'b0, 32'h0, 32'h0000_4C4B, 1'b0);
        pushExp(M1, 16'h0050, 1'b0, 32'h0, 32'h0000_4C4B, 1'b0);
        driveMaster(M0, 1'b1, 16'h0040, 1'b0, 32'h0, 1'b1);
        driveMaster(M1, 1'b1, 16'h0050, 1'b0, 32'h0, 1'b0);
        waitAcks(6);
        @(posedge clk); #1;
        driveMaster(M0, 1'b0, '0, 1'b0, '0, 1'b0);
        driveMaster(M1, 1'b0, '0, 1'b0, '0, 1'b0);

        $display("[TB] reset during issue");
        doReset();
        slave_data = 32'hBAD0BAD0;
        exp_bus.push_back('{addr: 16'h0060, we: 1'b0, wdata: 32'h0});
        driveMaster(M0, 1'b1, 16'h0060, 1'b0, 32'h0, 1'b0);
        spins = 0;
        do begin
            @(posedge clk); #1;
            spins++;
        end while (bus_sel !== 1'b1 && spins < 10);
        if (bus_sel !== 1'b1) failNow("issue_timeout");
        rst = 1'b1;
        driveMaster(M0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_sel", 64'(bus_sel), 64'(0));
        checkOutput("abort_ack", 64'(m0_if.ack), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(M0, 16'h0060, 1'b0, 32'h0, 32'hA5A50060, 1'b0, 32'hA5A50060, 1'b0, waits);

        $display("[TB] back-to-back writes");
        sel_cycles.delete();
        applyStimulus(M1, 16'h0100, 1'b1, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, waits);
        applyStimulus(M1, 16'h0104, 1'b1, 32'h2, 32'h0, 1'b0, 32'h0, 1'b0, waits);
        applyStimulus(M1, 16'h0108, 1'b1, 32'h3, 32'h0, 1'b0, 32'h0, 1'b0, waits);
        checkOutput("b2b_sel_count", 64'(sel_cycles.size()), 64'(3));
        for (int i = 1; i < sel_cycles.size(); i++)
            checkOutput("b2b_spacing", 64'(sel_cycles[i] - sel_cycles[i-1]), 64'(3));

        repeat (5) @(posedge clk);
        #1;
        checkOutput("bus_queue_empty", 64'(exp_bus.size()), 64'(0));
        checkOutput("ack_queue_empty", 64'(exp_ack.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
